// File: rtl/breadboard_sweep_ctrl_if.sv
// Host/breadboard bundle for the sweep controller: sweep control, breadboard drive/sense, result readback.
interface breadboard_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [3:0] idx;
  logic       w;
  logic       x;
  logic       y;
  logic       z;
  logic       f4;
  logic       f5;
  logic       f6;
  logic [3:0] rd_addr;
  logic [2:0] rd_data;
  logic       rd_valid;
  logic [4:0] mismatch_cnt;
  logic       fail_valid;
  logic [3:0] first_fail;

  modport slave (
    input  start, abort, f4, f5, f6, rd_addr,
    output busy, done, idx, w, x, y, z, rd_data, rd_valid,
           mismatch_cnt, fail_valid, first_fail
  );

  modport master (
    output start, abort, f4, f5, f6, rd_addr,
    input  busy, done, idx, w, x, y, z, rd_data, rd_valid,
           mismatch_cnt, fail_valid, first_fail
  );
endinterface

// File: rtl/breadboard_sweep_ctrl.sv
// Steps the breadboard through a code range, captures f4/f5/f6 per code and optionally scores them.
// Optional golden compare: define BREADBOARD_SWEEP_GOLDEN_CHECK_EN.
module breadboard_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned START_CODE    = 0,
  parameter int unsigned END_CODE      = 15
) (
  input logic                    clk,
  input logic                    rst_n,
  breadboard_sweep_ctrl_if.slave bus
);

  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DATA_W = 3;
  localparam int unsigned DEPTH  = 16;

  localparam logic [CODE_W-1:0] START_L  = CODE_W'(START_CODE);
  localparam logic [CODE_W-1:0] END_L    = CODE_W'(END_CODE);
  localparam logic [CODE_W-1:0] SETTLE_L = CODE_W'(SETTLE_CYCLES);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]                    state_q, state_d;
  logic [CODE_W-1:0]             idx_q, idx_d;
  logic [CODE_W-1:0]             drv_q, drv_d;
  logic [CODE_W-1:0]             settle_q, settle_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][DATA_W-1:0]  tbl_q, tbl_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          fv_q, fv_d;
  logic [CODE_W-1:0]             ff_q, ff_d;
  logic [DATA_W-1:0]             sample_c;

  assign sample_c = {bus.f6, bus.f5, bus.f4};

`ifdef BREADBOARD_SWEEP_GOLDEN_CHECK_EN
  // Expected {f6,f5,f4} of a healthy breadboard for code {w,x,y,z}.
  function automatic logic [DATA_W-1:0] golden(input logic [CODE_W-1:0] c);
    logic w, x, y, z, f4, f5, f6;
    {w, x, y, z} = c;
    f4 = y & z;
    f5 = (~y & ~z) | (~w & ~x);
    f6 = (~w & ~x & z) | (~w & ~x & y) | (x & ~y & z) | (w & ~x & ~y & ~z);
    return {f6, f5, f4};
  endfunction
`endif

  // Next-state and datapath; abort freezes everything except the state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drv_d    = drv_q;
    settle_d = settle_q;
    valid_d  = valid_q;
    tbl_d    = tbl_q;
    cnt_d    = cnt_q;
    fv_d     = fv_q;
    ff_d     = ff_q;

    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            idx_d   = START_L;
            valid_d = '0;
            cnt_d   = '0;
            fv_d    = 1'b0;
            ff_d    = '0;
            state_d = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          drv_d    = idx_q;
          settle_d = SETTLE_L;
          state_d  = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_SAMPLE;
        end
        ST_SETTLE: begin
          settle_d = settle_q - CODE_W'(1);
          if (settle_q == CODE_W'(1)) state_d = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          tbl_d[idx_q]   = sample_c;
          valid_d[idx_q] = 1'b1;
`ifdef BREADBOARD_SWEEP_GOLDEN_CHECK_EN
          if (sample_c != golden(idx_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!fv_q) begin
              fv_d = 1'b1;
              ff_d = idx_q;
            end
          end
`endif
          if (idx_q == END_L) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + CODE_W'(1);
            state_d = ST_DRIVE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      drv_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= '0;
      tbl_q    <= '0;
      cnt_q    <= '0;
      fv_q     <= 1'b0;
      ff_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drv_q    <= drv_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      tbl_q    <= tbl_d;
      cnt_q    <= cnt_d;
      fv_q     <= fv_d;
      ff_q     <= ff_d;
    end
  end

  assign {bus.w, bus.x, bus.y, bus.z} = drv_q;
  assign bus.idx          = idx_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.rd_data      = tbl_q[bus.rd_addr];
  assign bus.rd_valid     = valid_q[bus.rd_addr];
  assign bus.mismatch_cnt = cnt_q;
  assign bus.fail_valid   = fv_q;
  assign bus.first_fail   = ff_q;

endmodule
